config_reg_initiator: RTL and testbench

CONFIG_REG_INITIATOR -- requirements
Module: config_reg_initiator

---
 rtl/config_reg_initiator.sv | 183 ++++++++++++++++++
 tb/tb_config_reg_initiator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_reg_initiator.sv
// -----------------------------------------------------------------------------
// config_reg_initiator
//
// Purpose:
//   Host-side initiator for an 8-entry configuration register target. The host
//   issues one read or write request at a time. The initiator drives a command
//   packet and a single strobe toward the target. For reads it waits a bounded
//   number of cycles for the target response and checks that response. It then
//   holds the result for the host until the host accepts it. Writes can
//   optionally be confirmed by a read-back compare.
//
// Parameters:
//   WIDTH          packet width in bits. Must be at least 32, because the
//                  target response is WIDTH-3 bits and carries a 29-bit frame.
//   TIMEOUT        maximum number of RD cycles spent waiting for target valid
//   VERIFY_WRITES  1 = every write is followed by a read-back compare
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        host request handshake (ready only in IDLE)
//   req_write/addr/wdata       request fields: 1 = write, register 0-7, 24b data
//   packet                     command to target: [26:24] addr, [23:0] data
//   cfg_write_en/cfg_read_en   target strobes (mutually exclusive)
//   read_data/valid            target response {2'b10, addr, data} and its valid
//   rsp_valid/rsp_ready        host response handshake
//   rsp_addr/data/status       completed register index, data, status code
//   err_count                  saturating count of non-OK responses
// -----------------------------------------------------------------------------
module config_reg_initiator #(
    parameter int WIDTH         = 32,
    parameter int TIMEOUT       = 15,
    parameter int VERIFY_WRITES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_addr,
    input  logic [23:0]      req_wdata,
    output logic [WIDTH-1:0] packet,
    output logic             cfg_write_en,
    output logic             cfg_read_en,
    input  logic [WIDTH-4:0] read_data,
    input  logic             valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_addr,
    output logic [23:0]      rsp_data,
    output logic [1:0]       rsp_status,
    output logic [7:0]       err_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_HEADER  = 2'b10;
    localparam logic [1:0] ST_VERIFY  = 2'b11;

    // The wait counter runs 0..TIMEOUT-1 across the TIMEOUT RD cycles.
    localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_write;
    logic [2:0]       addr_q;
    logic [23:0]      wdata_q;
    logic [1:0]       rd_st;

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Classify a target response. The header is checked first. The data
    // compare only applies when the read is a write verification.
    function automatic logic [1:0] rd_status(input logic [WIDTH-4:0] rd,
                                             input logic [2:0]       a,
                                             input logic [23:0]      w,
                                             input logic             vfy);
        if (rd[28:27] != 2'b10 || rd[26:24] != a)
            return ST_HEADER;
        else if (vfy && rd[23:0] != w)
            return ST_VERIFY;
        else
            return ST_OK;
    endfunction

    assign rd_st = rd_status(read_data, addr_q, wdata_q, is_write);

    // Request fields are pure data and are only meaningful outside IDLE.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            is_write   <= 1'b0;
            rsp_addr   <= 3'd0;
            rsp_data   <= 24'd0;
            rsp_status <= ST_OK;
            err_count  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        is_write <= req_write;
                        wait_cnt <= '0;
                        state    <= req_write ? S_WR : S_RD;
                    end
                end
                S_WR: begin
                    if (VERIFY_WRITES != 0) begin
                        wait_cnt <= '0;
                        state    <= S_RD;
                    end else begin
                        rsp_addr   <= addr_q;
                        rsp_data   <= wdata_q;
                        rsp_status <= ST_OK;
                        state      <= S_RESP;
                    end
                end
                S_RD: begin
                    if (valid) begin
                        rsp_addr   <= addr_q;
                        rsp_data   <= read_data[23:0];
                        rsp_status <= rd_st;
                        if (rd_st != ST_OK)
                            err_count <= sat_inc(err_count);
                        state <= S_RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_addr   <= addr_q;
                        rsp_data   <= 24'd0;
                        rsp_status <= ST_TIMEOUT;
                        err_count  <= sat_inc(err_count);
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes and packet decode straight from state, so an asynchronous reset
    // removes them immediately.
    always_comb begin
        packet       = '0;
        cfg_write_en = 1'b0;
        cfg_read_en  = 1'b0;
        case (state)
            S_WR: begin
                cfg_write_en = 1'b1;
                packet[26:0] = {addr_q, wdata_q};
            end
            S_RD: begin
                cfg_read_en  = 1'b1;
                packet[26:0] = {addr_q, 24'h000000};
            end
            default: begin
            end
        endcase
    end

    // rst_n gates ready so that no request can be accepted while reset is low.
    assign req_ready = (state == S_IDLE) && rst_n;
    assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_config_reg_initiator.sv
module tb_config_reg_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    int          total = 0;
    int          bad   = 0;

    // Instance without write verification, default timeout.
    logic        req_valid, req_write, valid, rsp_ready;
    logic [2:0]  req_addr;
    logic [23:0] req_wdata;
    logic [28:0] read_data;
    logic        req_ready, cfg_write_en, cfg_read_en, rsp_valid;
    logic [31:0] packet;
    logic [2:0]  rsp_addr;
    logic [23:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [7:0]  err_count;

    // Instance with write verification and a short timeout.
    logic        v_req_valid, v_req_write, v_valid, v_rsp_ready;
    logic [2:0]  v_req_addr;
    logic [23:0] v_req_wdata;
    logic [28:0] v_read_data;
    logic        v_req_ready, v_cfg_write_en, v_cfg_read_en, v_rsp_valid;
    logic [31:0] v_packet;
    logic [2:0]  v_rsp_addr;
    logic [23:0] v_rsp_data;
    logic [1:0]  v_rsp_status;
    logic [7:0]  v_err_count;

    always #5 clk = ~clk;

    config_reg_initiator #(.WIDTH(32), .TIMEOUT(15), .VERIFY_WRITES(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .packet(packet), .cfg_write_en(cfg_write_en), .cfg_read_en(cfg_read_en),
        .read_data(read_data), .valid(valid), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .err_count(err_count)
    );

    config_reg_initiator #(.WIDTH(32), .TIMEOUT(2), .VERIFY_WRITES(1)) dut_v (
        .clk(clk), .rst_n(rst_n), .req_valid(v_req_valid), .req_ready(v_req_ready),
        .req_write(v_req_write), .req_addr(v_req_addr), .req_wdata(v_req_wdata),
        .packet(v_packet), .cfg_write_en(v_cfg_write_en), .cfg_read_en(v_cfg_read_en),
        .read_data(v_read_data), .valid(v_valid), .rsp_valid(v_rsp_valid),
        .rsp_ready(v_rsp_ready), .rsp_addr(v_rsp_addr), .rsp_data(v_rsp_data),
        .rsp_status(v_rsp_status), .err_count(v_err_count)
    );

    // All stimulus is applied in the low clock phase, just after a negedge.
    task automatic drive_req(input logic w, input logic [2:0] a, input logic [23:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic ack_resp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic v_drive_req(input logic w, input logic [2:0] a, input logic [23:0] d);
        v_req_valid = 1'b1; v_req_write = w; v_req_addr = a; v_req_wdata = d;
        @(negedge clk);
        v_req_valid = 1'b0;
    endtask

    task automatic v_ack_resp();
        v_rsp_ready = 1'b1;
        @(negedge clk);
        v_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        read_data = 0; valid = 0; rsp_ready = 0;
        v_req_valid = 0; v_req_write = 0; v_req_addr = 0; v_req_wdata = 0;
        v_read_data = 0; v_valid = 0; v_rsp_ready = 0;
        @(negedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        total++; if ({cfg_write_en, cfg_read_en} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b exp=00", {cfg_write_en, cfg_read_en}); end
        total++; if (packet !== 32'h0) begin bad++; $display("FAIL rst_packet got=%h exp=0", packet); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if ({rsp_status, rsp_data, rsp_addr} !== 29'h0) begin bad++; $display("FAIL rst_rsp_fields got=%h exp=0", {rsp_status, rsp_data, rsp_addr}); end
        total++; if (err_count !== 8'h00) begin bad++; $display("FAIL rst_err_count got=%h exp=00", err_count); end
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_write();
        drive_req(1'b1, 3'd3, 24'hABCDEF);
        total++; if (cfg_write_en !== 1'b1 || cfg_read_en !== 1'b0) begin bad++; $display("FAIL wr_strobes got=%b%b exp=10", cfg_write_en, cfg_read_en); end
        total++; if (packet !== 32'h03ABCDEF) begin bad++; $display("FAIL wr_packet got=%h exp=03abcdef", packet); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wr_req_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        total++; if (cfg_write_en !== 1'b0 || packet !== 32'h0) begin bad++; $display("FAIL wr_one_cycle got=%b/%h exp=0/0", cfg_write_en, packet); end
        total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00) begin bad++; $display("FAIL wr_rsp got=%b/%b exp=1/00", rsp_valid, rsp_status); end
        total++; if (rsp_data !== 24'hABCDEF || rsp_addr !== 3'd3) begin bad++; $display("FAIL wr_rsp_data got=%h/%0d exp=abcdef/3", rsp_data, rsp_addr); end
        ack_resp();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL wr_return_idle got=%b/%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_read();
        drive_req(1'b0, 3'd5, 24'h0);
        total++; if (cfg_read_en !== 1'b1 || cfg_write_en !== 1'b0) begin bad++; $display("FAIL rd_strobes got=%b%b exp=01", cfg_write_en, cfg_read_en); end
        total++; if (packet !== 32'h05000000) begin bad++; $display("FAIL rd_packet got=%h exp=05000000", packet); end
        valid = 1'b1; read_data = {2'b10, 3'd5, 24'h123456};
        @(negedge clk);
        valid = 1'b0; read_data = 29'h0;
        total++; if (rsp_valid !== 1'b1 || cfg_read_en !== 1'b0) begin bad++; $display("FAIL rd_latency got=%b/%b exp=1/0", rsp_valid, cfg_read_en); end
        total++; if (rsp_data !== 24'h123456 || rsp_status !== 2'b00 || rsp_addr !== 3'd5) begin bad++; $display("FAIL rd_rsp got=%h/%b/%0d exp=123456/00/5", rsp_data, rsp_status, rsp_addr); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rd_err_count got=%0d exp=0", err_count); end
        ack_resp();
    endtask

    task automatic test_timeout();
        int n;
        drive_req(1'b0, 3'd2, 24'h0);
        n = 0;
        while (cfg_read_en === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        total++; if (n != 15) begin bad++; $display("FAIL to_read_cycles got=%0d exp=15", n); end
        total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b01) begin bad++; $display("FAIL to_rsp got=%b/%b exp=1/01", rsp_valid, rsp_status); end
        total++; if (rsp_data !== 24'h0) begin bad++; $display("FAIL to_rsp_data got=%h exp=0", rsp_data); end
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL to_err_count got=%0d exp=1", err_count); end
        ack_resp();
    endtask

    task automatic test_bad_header();
        drive_req(1'b0, 3'd4, 24'h0);
        valid = 1'b1; read_data = {2'b01, 3'd4, 24'h00AAAA};
        @(negedge clk);
        valid = 1'b0;
        total++; if (rsp_status !== 2'b10 || rsp_data !== 24'h00AAAA) begin bad++; $display("FAIL hdr_rsp got=%b/%h exp=10/00aaaa", rsp_status, rsp_data); end
        total++; if (err_count !== 8'd2) begin bad++; $display("FAIL hdr_err_count got=%0d exp=2", err_count); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_data !== 24'h00AAAA ||
                rsp_addr !== 3'd4 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hdr_hold%0d got=%b/%b/%h/%0d/%b exp=1/10/00aaaa/4/0",
                         i, rsp_valid, rsp_status, rsp_data, rsp_addr, req_ready);
            end
        end
        ack_resp();
        drive_req(1'b0, 3'd6, 24'h0);
        valid = 1'b1; read_data = {2'b10, 3'd1, 24'h555555};
        @(negedge clk);
        valid = 1'b0;
        total++; if (rsp_status !== 2'b10 || rsp_data !== 24'h555555 || rsp_addr !== 3'd6) begin bad++; $display("FAIL addr_mismatch got=%b/%h/%0d exp=10/555555/6", rsp_status, rsp_data, rsp_addr); end
        total++; if (err_count !== 8'd3) begin bad++; $display("FAIL addr_err_count got=%0d exp=3", err_count); end
        ack_resp();
    endtask

    task automatic test_ignore_valid();
        valid = 1'b1; read_data = {2'b10, 3'd0, 24'h111111};
        @(negedge clk);
        @(negedge clk);
        valid = 1'b0;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || cfg_read_en !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b/%b/%b exp=0/1/0", rsp_valid, req_ready, cfg_read_en); end
        total++; if (err_count !== 8'd3) begin bad++; $display("FAIL idle_err_count got=%0d exp=3", err_count); end
    endtask

    task automatic test_reset_mid_rd();
        drive_req(1'b0, 3'd7, 24'h0);
        @(negedge clk);
        total++; if (cfg_read_en !== 1'b1) begin bad++; $display("FAIL mid_in_rd got=%b exp=1", cfg_read_en); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (cfg_read_en !== 1'b0 || packet !== 32'h0) begin bad++; $display("FAIL mid_async_drop got=%b/%h exp=0/0", cfg_read_en, packet); end
        total++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || err_count !== 8'd0) begin bad++; $display("FAIL mid_rst_state got=%b/%b/%0d exp=0/0/0", req_ready, rsp_valid, err_count); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_release got=%b/%b exp=1/0", req_ready, rsp_valid); end
        drive_req(1'b0, 3'd1, 24'h0);
        valid = 1'b1; read_data = {2'b10, 3'd1, 24'hC0FFEE};
        @(negedge clk);
        valid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_data !== 24'hC0FFEE) begin bad++; $display("FAIL mid_next_req got=%b/%b/%h exp=1/00/c0ffee", rsp_valid, rsp_status, rsp_data); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL mid_err_count got=%0d exp=0", err_count); end
        ack_resp();
    endtask

    task automatic test_verify();
        v_drive_req(1'b1, 3'd2, 24'h000001);
        total++; if (v_cfg_write_en !== 1'b1 || v_cfg_read_en !== 1'b0 || v_packet !== 32'h02000001) begin bad++; $display("FAIL vfy_wr got=%b%b/%h exp=10/02000001", v_cfg_write_en, v_cfg_read_en, v_packet); end
        @(negedge clk);
        total++; if (v_cfg_write_en !== 1'b0 || v_cfg_read_en !== 1'b1 || v_packet !== 32'h02000000) begin bad++; $display("FAIL vfy_rd got=%b%b/%h exp=01/02000000", v_cfg_write_en, v_cfg_read_en, v_packet); end
        v_valid = 1'b1; v_read_data = {2'b10, 3'd2, 24'h000002};
        @(negedge clk);
        v_valid = 1'b0;
        total++; if (v_rsp_valid !== 1'b1 || v_rsp_status !== 2'b11 || v_rsp_data !== 24'h000002) begin bad++; $display("FAIL vfy_mismatch got=%b/%b/%h exp=1/11/000002", v_rsp_valid, v_rsp_status, v_rsp_data); end
        total++; if (v_err_count !== 8'd1) begin bad++; $display("FAIL vfy_err_count got=%0d exp=1", v_err_count); end
        v_ack_resp();
        v_drive_req(1'b1, 3'd1, 24'h777777);
        @(negedge clk);
        v_valid = 1'b1; v_read_data = {2'b10, 3'd1, 24'h777777};
        @(negedge clk);
        v_valid = 1'b0;
        total++; if (v_rsp_status !== 2'b00 || v_rsp_data !== 24'h777777 || v_err_count !== 8'd1) begin bad++; $display("FAIL vfy_match got=%b/%h/%0d exp=00/777777/1", v_rsp_status, v_rsp_data, v_err_count); end
        v_ack_resp();
    endtask

    task automatic v_timeout_read();
        int n;
        v_drive_req(1'b0, 3'd0, 24'h0);
        n = 0;
        while (v_rsp_valid !== 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (v_rsp_valid !== 1'b1 || v_rsp_status !== 2'b01) begin
            bad++;
            $display("FAIL sat_timeout_rsp got=%b/%b exp=1/01", v_rsp_valid, v_rsp_status);
        end
        v_ack_resp();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 253; i++) v_timeout_read();
        total++; if (v_err_count !== 8'hFE) begin bad++; $display("FAIL sat_fe got=%h exp=fe", v_err_count); end
        v_timeout_read();
        total++; if (v_err_count !== 8'hFF) begin bad++; $display("FAIL sat_ff got=%h exp=ff", v_err_count); end
        v_timeout_read();
        total++; if (v_err_count !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%h exp=ff", v_err_count); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_bad_header();
        test_ignore_valid();
        test_reset_mid_rd();
        test_verify();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
